ser_neuron_array_ctrl: RTL and testbench

Parametrised command front end for the mixed-signal neuron grid: takes a byte-serial command stream from the SPI receiver, loads per-neuron weight/bias/sign registers and the shared input, runs a timed trigger/settle/capture cycle on the grid, and returns results. Sits between the SPI slave and a grid of `N_NEURONS` analog-backed neurons. Generalises neuron count and word width, adds a settle timer, output snapshotting, a busy/error interface and optional sequential read-out.

---
 rtl/ser_neuron_pkg.sv | 33 +++
 rtl/ser_neuron_readout.sv | 71 +++++++
 rtl/ser_neuron_array_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ser_neuron_array_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_neuron_pkg.sv
// Shared types for the serial neuron-array command front end.
// Opcode and FSM state enums plus command-word field offsets.
package ser_neuron_pkg;

  // Opcode occupies the top OP_W bits, the sign flag sits just below it.
  localparam int unsigned OP_W  = 2;
  localparam int unsigned HDR_W = 3;

  typedef enum logic [1:0] {
    LOAD_WIN  = 2'd0,
    LOAD_BIAS = 2'd1,
    LOAD_DIN  = 2'd2,
    RUN       = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARG     = 3'd1,
    TRIG    = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    READ    = 3'd5
  } state_e;

  function automatic int unsigned op_lsb(input int unsigned data_w);
    return data_w - OP_W;
  endfunction

  function automatic int unsigned sign_pos(input int unsigned data_w);
    return data_w - HDR_W;
  endfunction

endpackage

// File: rtl/ser_neuron_readout.sv
// Result snapshot and read-out sequencer for the neuron array.
// SER_NEURON_SCAN_READOUT_EN selects full sequential read-out of all neurons.
module ser_neuron_readout
  import ser_neuron_pkg::*;
#(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture,
  input  logic                          read,
  input  logic [$clog2(N_NEURONS)-1:0]  id,
  input  logic [N_NEURONS*DATA_W-1:0]   grid_dout,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          last_c
);

  localparam int unsigned ID_W = $clog2(N_NEURONS);

`ifdef SER_NEURON_SCAN_READOUT_EN

  logic [DATA_W-1:0] snapshot [N_NEURONS];
  logic [ID_W:0]     idx;

  assign last_c = read && (idx == (ID_W+1)'(N_NEURONS));

  // Word 0 goes out on the capture edge, the rest stream from the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N_NEURONS); k++) snapshot[k] <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (capture) begin
      for (int k = 0; k < int'(N_NEURONS); k++) snapshot[k] <= grid_dout[k*DATA_W +: DATA_W];
      dout       <= grid_dout[DATA_W-1:0];
      dout_valid <= 1'b1;
      idx        <= (ID_W+1)'(1);
    end else if (read) begin
      if (last_c) begin
        dout_valid <= 1'b0;
      end else begin
        dout <= snapshot[idx[ID_W-1:0]];
        idx  <= idx + (ID_W+1)'(1);
      end
    end
  end

`else

  logic [DATA_W-1:0] snapshot;

  assign last_c = read;
  assign dout   = snapshot;

  // Only the selected neuron is kept; it doubles as the held output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot   <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= capture;
      if (capture) snapshot <= grid_dout[32'(id)*DATA_W +: DATA_W];
    end
  end

`endif

endmodule

// File: rtl/ser_neuron_array_ctrl.sv
// Byte-serial command front end for the mixed-signal neuron grid.
// Optional macro SER_NEURON_SCAN_READOUT_EN enables sequential read-out.
module ser_neuron_array_ctrl
  import ser_neuron_pkg::*;
#(
  parameter int unsigned N_NEURONS     = 8,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TRIG_CYCLES   = 1,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done_iw,
  input  logic [DATA_W-1:0]             dout_iw,
  output logic [DATA_W-1:0]             din,
  output logic [N_NEURONS-1:0]          sign,
  output logic [N_NEURONS*DATA_W-1:0]   win,
  output logic [N_NEURONS*DATA_W-1:0]   bias,
  output logic                          trig,
  input  logic [N_NEURONS*DATA_W-1:0]   grid_dout,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned ID_W    = $clog2(N_NEURONS);
  localparam int unsigned OP_LSB  = op_lsb(DATA_W);
  localparam int unsigned S_BIT   = sign_pos(DATA_W);
  localparam int unsigned MAX_CYC = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e          state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  op_e             pend_op, pend_op_next;
  logic [ID_W-1:0] pend_id, pend_id_next;
  logic [ID_W-1:0] run_id, run_id_next;

  op_e             cmd_op;
  logic            cmd_s;
  logic [ID_W-1:0] cmd_id;
  logic            id_ok_c;
  logic            wr_win_c, wr_bias_c, wr_din_c, set_sign_c, err_set_c;
  logic            capture_c, read_c, last_c;

  assign cmd_op    = op_e'(dout_iw[DATA_W-1:OP_LSB]);
  assign cmd_s     = dout_iw[S_BIT];
  assign cmd_id    = dout_iw[ID_W-1:0];
  assign id_ok_c   = (32'(cmd_id) < N_NEURONS);
  assign capture_c = (state == CAPTURE);
  assign read_c    = (state == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_op <= LOAD_WIN;
      pend_id <= '0;
      run_id  <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_op <= pend_op_next;
      pend_id <= pend_id_next;
      run_id  <= run_id_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    pend_op_next = pend_op;
    pend_id_next = pend_id;
    run_id_next  = run_id;
    wr_win_c     = 1'b0;
    wr_bias_c    = 1'b0;
    wr_din_c     = 1'b0;
    set_sign_c   = 1'b0;
    err_set_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (done_iw) begin
          if ((cmd_op != LOAD_DIN) && !id_ok_c) begin
            err_set_c = 1'b1;
          end else if (cmd_op == RUN) begin
            state_next  = TRIG;
            run_id_next = cmd_id;
          end else begin
            state_next   = ARG;
            pend_op_next = cmd_op;
            pend_id_next = cmd_id;
            set_sign_c   = (cmd_op == LOAD_BIAS);
          end
        end
      end
      ARG: begin
        if (done_iw) begin
          state_next = IDLE;
          wr_win_c   = (pend_op == LOAD_WIN);
          wr_bias_c  = (pend_op == LOAD_BIAS);
          wr_din_c   = (pend_op == LOAD_DIN);
        end
      end
      TRIG: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = READ;
      READ: if (last_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Words arriving during an evaluation are dropped and flagged.
    if (done_iw && (state != IDLE) && (state != ARG)) err_set_c = 1'b1;
  end

  // Register file and status outputs, all following the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      din  <= '0;
      sign <= '0;
      win  <= '0;
      bias <= '0;
      trig <= 1'b0;
      busy <= 1'b0;
      err  <= 1'b0;
    end else begin
      trig <= (state_next == TRIG);
      busy <= (state_next != IDLE) && (state_next != ARG);
      err  <= err | err_set_c;
      if (set_sign_c) sign[cmd_id] <= cmd_s;
      if (wr_win_c)   win[32'(pend_id)*DATA_W +: DATA_W]  <= dout_iw;
      if (wr_bias_c)  bias[32'(pend_id)*DATA_W +: DATA_W] <= dout_iw;
      if (wr_din_c)   din <= dout_iw;
    end
  end

  ser_neuron_readout #(
    .N_NEURONS (N_NEURONS),
    .DATA_W    (DATA_W)
  ) u_readout (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture_c),
    .read       (read_c),
    .id         (run_id),
    .grid_dout  (grid_dout),
    .dout       (dout),
    .dout_valid (dout_valid),
    .last_c     (last_c)
  );

endmodule

// File: tb/tb_ser_neuron_array_ctrl.sv
// Scoreboard bench for ser_neuron_array_ctrl (N=8 main instance, N=6 range instance).
// Honours SER_NEURON_SCAN_READOUT_EN when building expected read-out words.
module tb_ser_neuron_array_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned N6 = 6;
`ifdef SER_NEURON_SCAN_READOUT_EN
  localparam int NV = 8;
`else
  localparam int NV = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           done_iw;
  logic [W-1:0]   dout_iw;
  logic [W-1:0]   din;
  logic [N-1:0]   sign;
  logic [N*W-1:0] win, bias, grid_dout;
  logic           trig, dout_valid, busy, err;
  logic [W-1:0]   dout;

  logic            done6;
  logic [W-1:0]    word6, din6, dout6;
  logic [N6-1:0]   sign6;
  logic [N6*W-1:0] win6, bias6;
  logic            trig6, dv6, busy6, err6;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] din_m;

  always #5 clk = ~clk;

  // Grid model: neuron k returns din + k.
  for (genvar k = 0; k < int'(N); k++) begin : g_grid
    assign grid_dout[k*W +: W] = din + W'(k);
  end

  ser_neuron_array_ctrl #(.N_NEURONS(N), .DATA_W(W), .TRIG_CYCLES(1), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .done_iw(done_iw), .dout_iw(dout_iw), .din(din), .sign(sign),
    .win(win), .bias(bias), .trig(trig), .grid_dout(grid_dout), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .err(err)
  );

  ser_neuron_array_ctrl #(.N_NEURONS(N6), .DATA_W(W), .TRIG_CYCLES(1), .SETTLE_CYCLES(4)) u_dut6 (
    .clk(clk), .rst(rst), .done_iw(done6), .dout_iw(word6), .din(din6), .sign(sign6),
    .win(win6), .bias(bias6), .trig(trig6), .grid_dout('0), .dout(dout6),
    .dout_valid(dv6), .busy(busy6), .err(err6)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid output word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %0h required no valid word", dout);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout_word: got %0h required %0h", dout, e);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    done_iw = 1'b1;
    dout_iw = w;
    @(negedge clk);
    done_iw = 1'b0;
  endtask

  task automatic send6(input logic [W-1:0] w);
    done6 = 1'b1;
    word6 = w;
    @(negedge clk);
    done6 = 1'b0;
  endtask

  // mode 0: plain RUN, 1: stray word during SETTLE, 2: reset during SETTLE
  task automatic run_cmd(input logic [W-1:0] cmd, input int mode);
    int first_v, nvalid, busy_low;
    if (mode != 2) begin
`ifdef SER_NEURON_SCAN_READOUT_EN
      for (int k = 0; k < int'(N); k++) exp_q.push_back(W'(din_m + W'(k)));
`else
      exp_q.push_back(W'(din_m + W'(cmd[2:0])));
`endif
    end
    send(cmd);
    first_v  = -1;
    nvalid   = 0;
    busy_low = -1;
    for (int cyc = 0; cyc < 40 && busy_low < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 0) begin
        chk("trig_rise", 64'(trig), 64'd1);
        chk("busy_rise", 64'(busy), 64'd1);
      end
      if (cyc == 1) chk("trig_fall", 64'(trig), 64'd0);
      if (mode == 1 && cyc == 2) begin
        done_iw = 1'b1;
        dout_iw = 8'h00;
      end
      if (mode == 1 && cyc == 3) begin
        done_iw = 1'b0;
        chk("err_busy_word", 64'(err), 64'd1);
      end
      if (mode == 2 && cyc == 2) rst = 1'b1;
      if (mode == 2 && cyc == 3) begin
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_win", win, 64'd0);
        chk("rst_bias", bias, 64'd0);
        chk("rst_sign", 64'(sign), 64'd0);
        chk("rst_din", 64'(din), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        rst   = 1'b0;
        din_m = '0;
        return;
      end
      if (dout_valid) begin
        if (first_v < 0) first_v = cyc;
        nvalid++;
      end
      if (!busy && busy_low < 0) busy_low = cyc;
    end
    chk("valid_latency", 64'(first_v), 64'd6);
    chk("valid_count", 64'(nvalid), 64'(NV));
    chk("busy_fall", 64'(busy_low), 64'(6 + NV));
  endtask

  initial begin
    rst     = 1'b1;
    done_iw = 1'b0;
    dout_iw = '0;
    done6   = 1'b0;
    word6   = '0;
    din_m   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_win", win, 64'd0);
    chk("reset_bias", bias, 64'd0);
    chk("reset_sign", 64'(sign), 64'd0);
    chk("reset_din", 64'(din), 64'd0);
    chk("reset_trig", 64'(trig), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_dout_valid", 64'(dout_valid), 64'd0);

    send(8'h03); send(8'h5A);
    chk("win3", win, 64'h00000000_5A000000);
    send(8'h65); send(8'h81);
    chk("bias5", bias, 64'h00008100_00000000);
    chk("sign5", 64'(sign), 64'h20);
    send(8'h80); send(8'h0F);
    din_m = 8'h0F;
    chk("din", 64'(din), 64'h0F);
    chk("no_err_after_loads", 64'(err), 64'd0);

    run_cmd(8'hC2, 0);
    // Immediately after busy falls: back-to-back load.
    send(8'h04); send(8'h77);
    chk("win4_b2b", win, 64'h00000077_5A000000);

    run_cmd(8'hC1, 1);
    chk("err_sticky", 64'(err), 64'd1);
    chk("win_after_stray", win, 64'h00000077_5A000000);

    send6(8'h07);
    chk("n6_err", 64'(err6), 64'd1);
    chk("n6_no_write", 64'(win6), 64'd0);
    chk("n6_idle", 64'(busy6), 64'd0);
    send6(8'hC6);
    chk("n6_run_dropped", 64'(trig6), 64'd0);
    send6(8'h05); send6(8'h99);
    chk("n6_win5", 64'(win6), 64'h9900_0000_0000);

    run_cmd(8'hC0, 2);
    send(8'h01); send(8'h33);
    chk("fresh_win1", win, 64'h00000000_00003300);

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish within 200000");
    $fatal(1, "timeout");
  end

endmodule
